// File: rtl/nios_system_stream_writer.sv
// Packs an 8-bit stream into 32-bit LE words and writes them into a ring buffer via memory port 2.
// Latency: a committing byte's write strobes (chipselect2/write2) are high for exactly the cycle after its accept edge.
// Backpressure: in_ready = enable & !full, from registered pointers; a disabled block keeps any partial word.
module nios_system_stream_writer #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_endofpacket,
    output logic [ADDR_W-1:0] address2,
    output logic [3:0]        byteenable2,
    output logic              chipselect2,
    output logic              write2,
    output logic [31:0]       writedata2,
    output logic              clken2,
    input  logic [2:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] RING_WORDS = {1'b1, {ADDR_W{1'b0}}};

    logic              ctrl_en;
    logic              ctrl_irq_en;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [1:0]        lane;
    logic [23:0]       pack;
    logic              eop_seen;
    logic              wr_stb;

    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  wptr_x;
    logic [LEN_W-1:0]  rptr_x;
    logic [LEN_W-1:0]  fill;
    logic [LEN_W-1:0]  rptr_mod;
    logic [ADDR_W-1:0] wptr_next;
    logic              full;
    logic              empty;
    logic              csr_wr;
    logic              soft_clear;
    logic              accept;
    logic              commit;
    logic [31:0]       word;
    logic [3:0]        word_be;

    wire unused_wdata = &{1'b0, csr_writedata[30:LEN_W]};

    assign len_eff   = (length == '0 || length > RING_WORDS) ? RING_WORDS : length;
    assign wptr_x    = {1'b0, wptr};
    assign rptr_x    = {1'b0, rptr};
    assign fill      = (wptr_x >= rptr_x) ? (wptr_x - rptr_x) : (wptr_x + len_eff - rptr_x);
    assign full      = (fill == len_eff - LEN_W'(1));
    assign empty     = (fill == '0);
    assign wptr_next = (wptr_x == len_eff - LEN_W'(1)) ? '0 : wptr + ADDR_W'(1);
    assign rptr_mod  = {1'b0, csr_writedata[ADDR_W-1:0]} % len_eff;

    assign csr_wr     = csr_chipselect & csr_write;
    // BASE/LENGTH writes and CTRL bit31 restart the ring; a clear beats a same-cycle byte.
    assign soft_clear = csr_wr & (((csr_address == 3'd0) & csr_writedata[31]) |
                                  (csr_address == 3'd1) | (csr_address == 3'd2));
    assign in_ready   = ctrl_en & ~full;
    assign accept     = in_valid & in_ready & ~soft_clear;
    assign commit     = accept & ((lane == 2'd3) | in_endofpacket);

    assign chipselect2 = wr_stb;
    assign write2      = wr_stb;
    assign clken2      = 1'b1;
    assign irq         = ctrl_irq_en & eop_seen;

    // Assemble the outgoing word: stored lanes below 'lane', the current byte at 'lane', zeros above.
    always_comb begin
        word    = '0;
        word_be = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(lane)) begin
                word[8*i +: 8] = pack[8*i +: 8];
                word_be[i]     = 1'b1;
            end
        end
        word[{lane, 3'b000} +: 8] = in_data;
        word_be[lane]             = 1'b1;
    end

    // CSR configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            base        <= '0;
            length      <= '0;
        end else if (csr_wr) begin
            case (csr_address)
                3'd0: begin
                    ctrl_en     <= csr_writedata[0];
                    ctrl_irq_en <= csr_writedata[1];
                end
                3'd1: base   <= csr_writedata[ADDR_W-1:0];
                3'd2: length <= csr_writedata[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Ring pointers, pack register and sticky end-of-packet flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            lane     <= '0;
            pack     <= '0;
            eop_seen <= 1'b0;
        end else if (soft_clear) begin
            wptr     <= '0;
            rptr     <= '0;
            lane     <= '0;
            eop_seen <= 1'b0;
        end else begin
            if (commit) begin
                wptr <= wptr_next;
                lane <= '0;
            end else if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    if (lane == 2'(i)) pack[8*i +: 8] <= in_data;
                end
                lane <= lane + 2'd1;
            end
            if (csr_wr && csr_address == 3'd4) rptr <= rptr_mod[ADDR_W-1:0];
            if (commit && in_endofpacket) begin
                eop_seen <= 1'b1;
            end else if (csr_wr && csr_address == 3'd5 && csr_writedata[2]) begin
                eop_seen <= 1'b0;
            end
        end
    end

    // Memory port 2 write register: one strobe cycle per committed word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_stb      <= 1'b0;
            address2    <= '0;
            writedata2  <= '0;
            byteenable2 <= '0;
        end else begin
            wr_stb <= commit;
            if (commit) begin
                address2    <= base + wptr;
                writedata2  <= word;
                byteenable2 <= word_be;
            end
        end
    end

    // Zero-wait CSR read mux.
    always_comb begin
        csr_readdata = '0;
        if (csr_chipselect && csr_read) begin
            case (csr_address)
                3'd0: csr_readdata[1:0]        = {ctrl_irq_en, ctrl_en};
                3'd1: csr_readdata[ADDR_W-1:0] = base;
                3'd2: csr_readdata[LEN_W-1:0]  = length;
                3'd3: csr_readdata[ADDR_W-1:0] = wptr;
                3'd4: csr_readdata[ADDR_W-1:0] = rptr;
                3'd5: begin
                    csr_readdata[0]          = full;
                    csr_readdata[1]          = empty;
                    csr_readdata[2]          = eop_seen;
                    csr_readdata[16 +: LEN_W] = fill;
                end
                default: ;
            endcase
        end
    end

endmodule
